// File: rtl/forwarding_pkg.sv
// Shared types for the LEGv8 forwarding/hazard unit: operand-select encoding,
// pipeline destination records and the XZR index.
package forwarding_pkg;

    localparam int REG_AW = 5;
    localparam int XZR    = 31;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EX = 2'b01,
        FWD_WB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regWrite;
        logic              memRead;
    } stage_info_t;

endpackage

// File: rtl/forwarding_unit_dest_stage_reg.sv
// One pipeline destination record (EX, MEM or WB); bubble loads an all-zero
// record so the slot can never act as a forwarding source.
module dest_stage_reg
    import forwarding_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble,
    input  stage_info_t d,
    output stage_info_t q
);

    stage_info_t info_d;
    stage_info_t info_q;

    always_comb begin
        info_d = bubble ? '0 : d;
    end

    // NOTE: sequential state uses non-blocking assignments so every record
    // samples the pre-edge value of the record feeding it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            info_q <= '0;
        end else begin
            info_q <= info_d;
        end
    end

    assign q = info_q;

endmodule

// File: rtl/forwarding_unit.sv
// Forwarding-select and load-use stall controller for the LEGv8 EX stage.
// Optional saturating stall/forward counters are built when FWD_STATS_EN is defined.
module forwarding_unit
    import forwarding_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int ZR    = XZR
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             flush,
    output logic [1:0]       rnSRC,
    output logic [1:0]       rmSRC,
    output logic             stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]      stall_count,
    output logic [31:0]      fwd_count
`endif
);

    localparam logic [REG_AW-1:0] ZR_A = REG_AW'(ZR);

    stage_info_t       id_info;
    stage_info_t       ex_q;
    stage_info_t       mem_q;
    stage_info_t       wb_q;
    logic              bubble;
    logic [REG_AW-1:0] rn_a;
    logic [REG_AW-1:0] rm_a;
    fwd_sel_e          rn_src_d;
    fwd_sel_e          rn_src_q;
    fwd_sel_e          rm_src_d;
    fwd_sel_e          rm_src_q;

    function automatic logic hit(input stage_info_t s, input logic [REG_AW-1:0] a);
        return s.valid && s.regWrite && (s.rd != ZR_A) && (s.rd == a);
    endfunction

    function automatic fwd_sel_e pick(input stage_info_t ex, input stage_info_t mem,
                                      input logic [REG_AW-1:0] a);
        if (hit(ex, a))       return FWD_EX;
        else if (hit(mem, a)) return FWD_WB;
        else                  return FWD_RF;
    endfunction

    assign rn_a = REG_AW'(id_rn);
    assign rm_a = REG_AW'(id_rm);

    assign stall  = id_valid && !flush && ex_q.memRead && (hit(ex_q, rn_a) || hit(ex_q, rm_a));
    assign bubble = stall || flush;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        id_info          = '0;
        id_info.valid    = id_valid;
        id_info.rd       = REG_AW'(id_rd);
        id_info.regWrite = id_regWrite;
        id_info.memRead  = id_memRead;
        rn_src_d         = FWD_RF;
        rm_src_d         = FWD_RF;
        if (!bubble) begin
            rn_src_d = pick(ex_q, mem_q, rn_a);
            rm_src_d = pick(ex_q, mem_q, rm_a);
        end
    end

    dest_stage_reg u_ex  (.clk(clk), .reset(reset), .bubble(bubble), .d(id_info), .q(ex_q));
    dest_stage_reg u_mem (.clk(clk), .reset(reset), .bubble(1'b0),   .d(ex_q),    .q(mem_q));
    dest_stage_reg u_wb  (.clk(clk), .reset(reset), .bubble(1'b0),   .d(mem_q),   .q(wb_q));

    // WB is tracked for completeness only: the register file writes on the falling edge.
    logic unused_fields;
    assign unused_fields = ^{wb_q, mem_q.memRead};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rn_src_q <= FWD_RF;
            rm_src_q <= FWD_RF;
        end else begin
            rn_src_q <= rn_src_d;
            rm_src_q <= rm_src_d;
        end
    end

    assign rnSRC = rn_src_q;
    assign rmSRC = rm_src_q;

`ifdef FWD_STATS_EN
    logic [31:0] stall_count_d;
    logic [31:0] stall_count_q;
    logic [31:0] fwd_count_d;
    logic [31:0] fwd_count_q;
    logic [1:0]  fwd_inc;
    logic [32:0] fwd_sum;

    always_comb begin
        fwd_inc       = {1'b0, rn_src_d != FWD_RF} + {1'b0, rm_src_d != FWD_RF};
        fwd_sum       = {1'b0, fwd_count_q} + 33'(fwd_inc);
        fwd_count_d   = fwd_sum[32] ? '1 : fwd_sum[31:0];
        stall_count_d = (stall && stall_count_q != '1) ? stall_count_q + 32'd1 : stall_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
            fwd_count_q   <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            fwd_count_q   <= fwd_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign fwd_count   = fwd_count_q;
`endif

endmodule
